// File: rtl/tx_sched_pkg.sv
// Shared definitions for the TX rate sequencers: FSM state encoding and
// the I/Q packing and counter widths used across the sample schedulers.
package tx_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2,
    FLUSH = 2'd3
  } tx_state_t;

  localparam int DEF_IBITS   = 20;
  localparam int USED_W      = 12;
  localparam int CE_CNT_W    = 8;
  localparam int FLUSH_CNT_W = 8;

  // The transmitter is considered live while samples or flush zeros flow.
  function automatic logic is_tx_active(input tx_state_t s);
    return (s == RUN) || (s == FLUSH);
  endfunction

endpackage

// File: rtl/ce_divider.sv
// Free-running clock-enable divider: ce is high for one clock out of every
// CE_DIV, on the clock where the internal count sits at CE_DIV-1.
module ce_divider
  import tx_sched_pkg::*;
#(
  parameter int CE_DIV = 1
) (
  input  logic clock,
  input  logic reset,
  output logic ce
);

  localparam logic [CE_CNT_W-1:0] TERM = CE_CNT_W'(CE_DIV - 1);

  logic [CE_CNT_W-1:0] div_q;
  logic [CE_CNT_W-1:0] div_d;
  logic                ce_q;
  logic                ce_d;

  // ce is registered alongside the count so it stays low while in reset,
  // including the CE_DIV=1 case where it is otherwise constantly high.
  always_comb begin
    div_d = (div_q == TERM) ? '0 : div_q + 1'b1;
    ce_d  = (div_d == TERM);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      div_q <= '0;
      ce_q  <= 1'b0;
    end else begin
      div_q <= div_d;
      ce_q  <= ce_d;
    end
  end

  assign ce = ce_q;

endmodule

// File: rtl/cic_interp_feeder.sv
// Feeds an interpolating CIC from a show-ahead TX FIFO: start-up priming,
// per-request sample hand-off, underrun zero substitution and flush drain.
module cic_interp_feeder
  import tx_sched_pkg::*;
#(
  parameter int IBITS       = DEF_IBITS,
  parameter int CE_DIV      = 1,
  parameter int PRIME_LEVEL = 32,
  parameter int FLUSH_SAMPS = 8,
  parameter int UWIDTH      = 16
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                tx_enable,
  input  logic [2*IBITS-1:0]  fifo_q,
  input  logic                fifo_empty,
  input  logic [USED_W-1:0]   fifo_used,
  output logic                fifo_rdreq,
  output logic                cic_ce,
  input  logic                cic_req,
  output logic [IBITS-1:0]    x_real,
  output logic [IBITS-1:0]    x_imag,
  output logic                tx_active,
  output logic                underrun,
  output logic [UWIDTH-1:0]   underrun_count
);

  localparam logic [USED_W-1:0]      PRIME_THR  = USED_W'(PRIME_LEVEL);
  localparam logic [FLUSH_CNT_W-1:0] FLUSH_LAST = FLUSH_CNT_W'(FLUSH_SAMPS - 1);

  tx_state_t               state_q, state_d;
  logic [IBITS-1:0]        x_real_q, x_real_d;
  logic [IBITS-1:0]        x_imag_q, x_imag_d;
  logic                    underrun_q, underrun_d;
  logic [UWIDTH-1:0]       underrun_count_q, underrun_count_d;
  logic [FLUSH_CNT_W-1:0]  flush_cnt_q, flush_cnt_d;
  logic                    tx_active_q, tx_active_d;

  ce_divider #(
    .CE_DIV (CE_DIV)
  ) u_ce_divider (
    .clock (clock),
    .reset (reset),
    .ce    (cic_ce)
  );

  // A tx_enable drop outranks a coincident request, so no pop happens then.
  assign fifo_rdreq = (state_q == RUN) & cic_req & ~fifo_empty & tx_enable;

  always_comb begin
    state_d          = state_q;
    x_real_d         = x_real_q;
    x_imag_d         = x_imag_q;
    underrun_d       = 1'b0;
    underrun_count_d = underrun_count_q;
    flush_cnt_d      = flush_cnt_q;

    case (state_q)
      IDLE: begin
        x_real_d = '0;
        x_imag_d = '0;
        if (tx_enable) begin
          underrun_count_d = '0;
          state_d          = PRIME;
        end
      end

      PRIME: begin
        x_real_d = '0;
        x_imag_d = '0;
        if (!tx_enable) begin
          state_d = IDLE;
        end else if (fifo_used >= PRIME_THR) begin
          state_d = RUN;
        end
      end

      RUN: begin
        if (!tx_enable) begin
          state_d     = FLUSH;
          flush_cnt_d = '0;
          x_real_d    = '0;
          x_imag_d    = '0;
        end else if (cic_req) begin
          if (!fifo_empty) begin
            x_real_d = fifo_q[2*IBITS-1:IBITS];
            x_imag_d = fifo_q[IBITS-1:0];
          end else begin
            x_real_d   = '0;
            x_imag_d   = '0;
            underrun_d = 1'b1;
            if (underrun_count_q != '1) begin
              underrun_count_d = underrun_count_q + 1'b1;
            end
          end
        end
      end

      FLUSH: begin
        // Zeros are held throughout so the CIC integrators drain to rest.
        x_real_d = '0;
        x_imag_d = '0;
        if (cic_req) begin
          flush_cnt_d = flush_cnt_q + 1'b1;
          if (flush_cnt_q == FLUSH_LAST) begin
            state_d = tx_enable ? PRIME : IDLE;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    tx_active_d = is_tx_active(state_d);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q          <= IDLE;
      x_real_q         <= '0;
      x_imag_q         <= '0;
      underrun_q       <= 1'b0;
      underrun_count_q <= '0;
      flush_cnt_q      <= '0;
      tx_active_q      <= 1'b0;
    end else begin
      state_q          <= state_d;
      x_real_q         <= x_real_d;
      x_imag_q         <= x_imag_d;
      underrun_q       <= underrun_d;
      underrun_count_q <= underrun_count_d;
      flush_cnt_q      <= flush_cnt_d;
      tx_active_q      <= tx_active_d;
    end
  end

  assign x_real         = x_real_q;
  assign x_imag         = x_imag_q;
  assign underrun       = underrun_q;
  assign underrun_count = underrun_count_q;
  assign tx_active      = tx_active_q;

endmodule
